// File: rtl/mips_cpu_pkg.sv
// Shared MIPS encodings for the ALU and the CPU.
// Contents: opcode (instr[31:26]) and R-type funct (instr[5:0]) enums,
// plus register-file geometry.
package mips_cpu_pkg;

  localparam int unsigned NumRegs  = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DataW    = 32;

  typedef enum logic [5:0] {
    OpRtype  = 6'b000000,
    OpRegimm = 6'b000001,
    OpJ      = 6'b000010,
    OpJal    = 6'b000011,
    OpBeq    = 6'b000100,
    OpBne    = 6'b000101,
    OpBlez   = 6'b000110,
    OpBgtz   = 6'b000111,
    OpAddi   = 6'b001000,
    OpAddiu  = 6'b001001,
    OpSlti   = 6'b001010,
    OpSltiu  = 6'b001011,
    OpAndi   = 6'b001100,
    OpOri    = 6'b001101,
    OpXori   = 6'b001110,
    OpLui    = 6'b001111
  } opcode_e;

  typedef enum logic [5:0] {
    FnSll   = 6'b000000,
    FnSrl   = 6'b000010,
    FnSra   = 6'b000011,
    FnSllv  = 6'b000100,
    FnSrlv  = 6'b000110,
    FnSrav  = 6'b000111,
    FnJr    = 6'b001000,
    FnJalr  = 6'b001001,
    FnMfhi  = 6'b010000,
    FnMthi  = 6'b010001,
    FnMflo  = 6'b010010,
    FnMtlo  = 6'b010011,
    FnMult  = 6'b011000,
    FnMultu = 6'b011001,
    FnDiv   = 6'b011010,
    FnDivu  = 6'b011011,
    FnAdd   = 6'b100000,
    FnAddu  = 6'b100001,
    FnSub   = 6'b100010,
    FnSubu  = 6'b100011,
    FnAnd   = 6'b100100,
    FnOr    = 6'b100101,
    FnXor   = 6'b100110,
    FnNor   = 6'b100111,
    FnSlt   = 6'b101010,
    FnSltu  = 6'b101011
  } funct_e;

endpackage

// File: rtl/mips_cpu_alu_regs_if.sv
// Bundle of the instruction fields, register ports and ALU results of
// mips_cpu_alu_regs.
// master: drives instruction fields, read/write indices, carry_in, write port.
// slave : drives register read data, ALU result and flags, register_v0.
interface mips_cpu_alu_regs_if;

  logic [5:0]  funct;
  logic [5:0]  opcode;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [4:0]  rs_index;
  logic [4:0]  rt_index;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        carry_in;
  logic [4:0]  write_index;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] alu_out;
  logic        branch;
  logic        carry_out;
  logic        zero;
  logic        link;
  logic [31:0] register_v0;

  modport master (
    output funct, opcode, shamt, imm, rs_index, rt_index, carry_in,
           write_index, write_enable, write_data,
    input  rs_data, rt_data, alu_out, branch, carry_out, zero, link, register_v0
  );

  modport slave (
    input  funct, opcode, shamt, imm, rs_index, rt_index, carry_in,
           write_index, write_enable, write_data,
    output rs_data, rt_data, alu_out, branch, carry_out, zero, link, register_v0
  );

endinterface

// File: rtl/mips_cpu_regs.sv
// 32 x 32-bit MIPS register file.
// Ports: clk, reset (sync, active-high, clears all registers),
//   rs_index/rt_index -> rs_data/rt_data (asynchronous reads),
//   write_index/write_enable/write_data (write on rising edge),
//   register_v0 (live copy of register 2).
// Register 0 reads as zero; reads never bypass a same-cycle write.
module mips_cpu_regs
  import mips_cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [RegAddrW-1:0] rs_index,
  input  logic [RegAddrW-1:0] rt_index,
  output logic [DataW-1:0]    rs_data,
  output logic [DataW-1:0]    rt_data,
  input  logic [RegAddrW-1:0] write_index,
  input  logic                write_enable,
  input  logic [DataW-1:0]    write_data,
  output logic [DataW-1:0]    register_v0
);

  logic [DataW-1:0] regs_q [NumRegs];
  logic [DataW-1:0] regs_d [NumRegs];

  always_comb begin
    regs_d = regs_q;
    if (write_enable && (write_index != '0)) begin
      regs_d[write_index] = write_data;
    end
    // Keep r0 at zero so it never holds anything but a constant.
    regs_d[0] = '0;
  end

  // Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // r0 is forced to zero on read as well, covering the pre-reset state.
  assign rs_data     = (rs_index == '0) ? '0 : regs_q[rs_index];
  assign rt_data     = (rt_index == '0) ? '0 : regs_q[rt_index];
  assign register_v0 = regs_q[2];

endmodule

// File: rtl/mips_cpu_alu_regs.sv
// MIPS register file plus combinational ALU / branch / link decode.
// Ports: clk, reset (sync, active-high, clears the register file only),
//   bus (slave): instruction fields, register read/write ports, carry_in,
//   alu_out, branch, carry_out, zero, link, register_v0.
// The ALU operands A and B are the rs and rt register read data.
module mips_cpu_alu_regs
  import mips_cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  mips_cpu_alu_regs_if.slave bus
);

  logic [31:0] a, b, se, ze;
  logic [32:0] sum_ab, sum_ai;
  logic        lt_s_ab, lt_u_ab, lt_s_ai, lt_u_ai;
  logic [31:0] alu_out;
  logic        carry_out, branch, link;
  opcode_e     op;
  funct_e      fn;

  mips_cpu_regs u_regs (
    .clk          (clk),
    .reset        (reset),
    .rs_index     (bus.rs_index),
    .rt_index     (bus.rt_index),
    .rs_data      (a),
    .rt_data      (b),
    .write_index  (bus.write_index),
    .write_enable (bus.write_enable),
    .write_data   (bus.write_data),
    .register_v0  (bus.register_v0)
  );

  assign bus.rs_data = a;
  assign bus.rt_data = b;

  assign op = opcode_e'(bus.opcode);
  assign fn = funct_e'(bus.funct);
  assign se = {{16{bus.imm[15]}}, bus.imm};
  assign ze = {16'h0000, bus.imm};

  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign sum_ai  = {1'b0, a} + {1'b0, se};
  assign lt_s_ab = $signed(a) < $signed(b);
  assign lt_u_ab = a < b;
  assign lt_s_ai = $signed(a) < $signed(se);
  assign lt_u_ai = a < se;

  always_comb begin
    alu_out   = '0;
    carry_out = bus.carry_in;
    branch    = 1'b0;
    link      = 1'b0;
    case (op)
      OpRtype: begin
        case (fn)
          FnSll:  alu_out = b << bus.shamt;
          FnSrl:  alu_out = b >> bus.shamt;
          FnSra:  alu_out = 32'($signed(b) >>> bus.shamt);
          FnSllv: alu_out = b << a[4:0];
          FnSrlv: alu_out = b >> a[4:0];
          FnSrav: alu_out = 32'($signed(b) >>> a[4:0]);
          FnAdd, FnAddu: begin
            alu_out   = sum_ab[31:0];
            carry_out = sum_ab[32];
          end
          FnSub, FnSubu: begin
            alu_out   = a - b;
            carry_out = lt_u_ab;  // borrow
          end
          FnAnd:  alu_out = a & b;
          FnOr:   alu_out = a | b;
          FnXor:  alu_out = a ^ b;
          FnNor:  alu_out = ~(a | b);
          FnSlt:  alu_out = {31'd0, lt_s_ab};
          FnSltu: alu_out = {31'd0, lt_u_ab};
          FnJalr: link = 1'b1;
          default: alu_out = '0;
        endcase
      end
      OpAddiu: begin
        alu_out   = sum_ai[31:0];
        carry_out = sum_ai[32];
      end
      OpSlti:   alu_out = {31'd0, lt_s_ai};
      OpSltiu:  alu_out = {31'd0, lt_u_ai};
      OpAndi:   alu_out = a & ze;
      OpOri:    alu_out = a | ze;
      OpXori:   alu_out = a ^ ze;
      OpLui:    alu_out = {bus.imm, 16'h0000};
      OpBeq:    branch = (a == b);
      OpBne:    branch = (a != b);
      OpBlez:   branch = a[31] | (a == '0);
      OpBgtz:   branch = ~a[31] & (a != '0);
      OpRegimm: branch = a[31];
      OpJal:    link = 1'b1;
      default:  alu_out = '0;
    endcase
  end

  assign bus.alu_out   = alu_out;
  assign bus.carry_out = carry_out;
  assign bus.branch    = branch;
  assign bus.link      = link;
  assign bus.zero      = (alu_out == '0);

endmodule

// File: tb/tb_mips_cpu_alu_regs.sv
module tb_mips_cpu_alu_regs;
  import mips_cpu_pkg::*;

  logic clk;
  logic reset;
  mips_cpu_alu_regs_if bus ();

  mips_cpu_alu_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_alu;
    logic        exp_br;
    logic        exp_cy;
    logic        exp_zero;
    logic        exp_lk;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [15:0] imm, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic [31:0] ealu,
                         input logic ebr, input logic ecy, input logic ezero,
                         input logic elk);
    vec_t v;
    v.name = name; v.opcode = opc; v.funct = fn; v.shamt = sh; v.imm = imm;
    v.a = a; v.b = b; v.cin = cin; v.exp_alu = ealu; v.exp_br = ebr;
    v.exp_cy = ecy; v.exp_zero = ezero; v.exp_lk = elk;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    bus.write_index  = idx;
    bus.write_data   = val;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.funct        = '0;
    bus.opcode       = '0;
    bus.shamt        = '0;
    bus.imm          = '0;
    bus.rs_index     = '0;
    bus.rt_index     = '0;
    bus.carry_in     = 1'b0;
    bus.write_index  = '0;
    bus.write_enable = 1'b0;
    bus.write_data   = '0;

    //       name       opcode    funct   sh  imm       A             B             cin alu           br cy z  lk
    add_vec("addu_wrap", OpRtype, FnAddu, 0, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 0, 1, 1, 0);
    add_vec("subu_brw",  OpRtype, FnSubu, 0, 16'h0000, 32'h00000003, 32'h00000005, 0, 32'hFFFFFFFE, 0, 1, 0, 0);
    add_vec("sub_pos",   OpRtype, FnSub,  0, 16'h0000, 32'h00000005, 32'h00000003, 1, 32'h00000002, 0, 0, 0, 0);
    add_vec("add_novf",  OpRtype, FnAdd,  0, 16'h0000, 32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 0, 0, 0, 0);
    add_vec("sra4",      OpRtype, FnSra,  4, 16'h0000, 32'h00000000, 32'h80000000, 1, 32'hF8000000, 0, 1, 0, 0);
    add_vec("srl31",     OpRtype, FnSrl, 31, 16'h0000, 32'h00000000, 32'h80000000, 0, 32'h00000001, 0, 0, 0, 0);
    add_vec("sllv",      OpRtype, FnSllv, 0, 16'h0000, 32'h00000024, 32'h00000001, 0, 32'h00000010, 0, 0, 0, 0);
    add_vec("nor",       OpRtype, FnNor,  0, 16'h0000, 32'h0F0F0F0F, 32'h00FF00FF, 0, 32'hF000F000, 0, 0, 0, 0);
    add_vec("slt",       OpRtype, FnSlt,  0, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000001, 0, 0, 0, 0);
    add_vec("sltu",      OpRtype, FnSltu, 0, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 0, 0, 1, 0);
    add_vec("mult_zero", OpRtype, FnMult, 0, 16'h0000, 32'h00000003, 32'h00000004, 0, 32'h00000000, 0, 0, 1, 0);
    add_vec("jalr",      OpRtype, FnJalr, 0, 16'h0000, 32'h00000040, 32'h00000000, 0, 32'h00000000, 0, 0, 1, 1);
    add_vec("lui",       OpLui,   FnSll,  0, 16'h1234, 32'h00000000, 32'h00000000, 0, 32'h12340000, 0, 0, 0, 0);
    add_vec("addiu",     OpAddiu, FnSll,  0, 16'hFFFF, 32'h00000010, 32'h00000000, 0, 32'h0000000F, 0, 1, 0, 0);
    add_vec("ori",       OpOri,   FnSll,  0, 16'h8000, 32'h00000000, 32'h00000000, 0, 32'h00008000, 0, 0, 0, 0);
    add_vec("xori",      OpXori,  FnSll,  0, 16'hFFFF, 32'hFFFF0000, 32'h00000000, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    add_vec("sltiu",     OpSltiu, FnSll,  0, 16'hFFFF, 32'h00000005, 32'h00000000, 0, 32'h00000001, 0, 0, 0, 0);
    add_vec("beq",       OpBeq,   FnSll,  0, 16'h0000, 32'h00000007, 32'h00000007, 1, 32'h00000000, 1, 1, 1, 0);
    add_vec("bne",       OpBne,   FnSll,  0, 16'h0000, 32'h00000001, 32'h00000002, 0, 32'h00000000, 1, 0, 1, 0);
    add_vec("bgtz_0",    OpBgtz,  FnSll,  0, 16'h0000, 32'h00000000, 32'h00000000, 0, 32'h00000000, 0, 0, 1, 0);
    add_vec("blez_neg",  OpBlez,  FnSll,  0, 16'h0000, 32'h80000000, 32'h00000000, 0, 32'h00000000, 1, 0, 1, 0);
    add_vec("bltz",      OpRegimm, FnSll, 0, 16'h0000, 32'hFFFFFFFF, 32'h00000000, 0, 32'h00000000, 1, 0, 1, 0);
    add_vec("jal",       OpJal,   FnSll,  0, 16'h0000, 32'h00000000, 32'h00000000, 0, 32'h00000000, 0, 0, 1, 1);

    // Reset state.
    do_reset();
    @(negedge clk);
    bus.rs_index = 5'd31;
    bus.rt_index = 5'd2;
    #1;
    check("rst_v0", bus.register_v0, 32'h0);
    check("rst_r31", bus.rs_data, 32'h0);
    check("rst_r2", bus.rt_data, 32'h0);

    // r2 write, visible on register_v0 and rt after the edge; reset clears it.
    write_reg(5'd2, 32'hDEADBEEF);
    check("v0_write", bus.register_v0, 32'hDEADBEEF);
    check("rt_r2", bus.rt_data, 32'hDEADBEEF);
    do_reset();
    check("v0_reset", bus.register_v0, 32'h0);
    check("rt_r2_reset", bus.rt_data, 32'h0);

    // Writes to r0 are discarded.
    write_reg(5'd0, 32'h5);
    bus.rs_index = 5'd0;
    #1;
    check("r0_zero", bus.rs_data, 32'h0);

    // No bypass: old value during the writing cycle, new after the edge.
    write_reg(5'd7, 32'h9);
    @(negedge clk);
    bus.rs_index     = 5'd7;
    bus.write_index  = 5'd7;
    bus.write_data   = 32'h1;
    bus.write_enable = 1'b1;
    #1;
    check("r7_old", bus.rs_data, 32'h9);
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    check("r7_new", bus.rs_data, 32'h1);

    // register_v0 holds the old value until the writing edge.
    @(negedge clk);
    bus.write_index  = 5'd2;
    bus.write_data   = 32'h0000_1111;
    bus.write_enable = 1'b1;
    #1;
    check("v0_before_edge", bus.register_v0, 32'h0);
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    check("v0_after_edge", bus.register_v0, 32'h0000_1111);

    // Reset beats a simultaneous write.
    write_reg(5'd5, 32'h1234_5678);
    @(negedge clk);
    reset            = 1'b1;
    bus.write_index  = 5'd5;
    bus.write_data   = 32'hAAAA_AAAA;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    reset            = 1'b0;
    bus.write_enable = 1'b0;
    bus.rs_index     = 5'd5;
    #1;
    check("rst_prio", bus.rs_data, 32'h0);

    // ALU vectors: A in r1, B in r3.
    foreach (vecs[i]) begin
      write_reg(5'd1, vecs[i].a);
      write_reg(5'd3, vecs[i].b);
      @(negedge clk);
      bus.rs_index = 5'd1;
      bus.rt_index = 5'd3;
      bus.opcode   = vecs[i].opcode;
      bus.funct    = vecs[i].funct;
      bus.shamt    = vecs[i].shamt;
      bus.imm      = vecs[i].imm;
      bus.carry_in = vecs[i].cin;
      #1;
      check({vecs[i].name, "_a"}, bus.rs_data, vecs[i].a);
      check({vecs[i].name, "_b"}, bus.rt_data, vecs[i].b);
      check({vecs[i].name, "_alu"}, bus.alu_out, vecs[i].exp_alu);
      check({vecs[i].name, "_branch"}, {31'd0, bus.branch}, {31'd0, vecs[i].exp_br});
      check({vecs[i].name, "_carry"}, {31'd0, bus.carry_out}, {31'd0, vecs[i].exp_cy});
      check({vecs[i].name, "_zero"}, {31'd0, bus.zero}, {31'd0, vecs[i].exp_zero});
      check({vecs[i].name, "_link"}, {31'd0, bus.link}, {31'd0, vecs[i].exp_lk});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
